mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/rr_picker.sv | 29 ++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the CPU memory subsystem. It holds the
//               arbiter state encoding and the default memory geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_DATA_WIDTH = 16;
    localparam int c_ADDR_WIDTH = 6;

    // Arbiter transaction states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Two-input round-robin selector. It is purely combinational.
//               When a single request is pending, that request wins. When
//               both are pending, the port that was not granted last wins.
// Ports       : req  [1:0] - request vector (bit 0 = r0, bit 1 = r1)
//               last       - last granted port (0 = r0, 1 = r1)
//               gnt  [1:0] - one-hot grant, all-zero when nothing requests
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin arbiter in front of a single-port
//               synchronous-read memory. Port r0 is the CPU. Port r1 is the
//               loader/debug port. One transaction is in flight at a time:
//               IDLE (accept) -> ISSUE -> [WAIT -> RESP for reads] -> IDLE.
// Ports       : clk, rst_n             - clock, async active-low reset
//               rX_req/we/addr/wdata   - requester X access request
//               rX_gnt                 - request accepted this cycle (IDLE only)
//               rX_rvalid/rdata        - one-cycle read response, shared data
//               mem_we/addr/wdata      - memory command (valid in ISSUE)
//               mem_rdata              - memory read data, one cycle after addr
//               busy                   - high while a transaction is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,

    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,

    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  busy
);

    arb_state_t            r_state;
    arb_state_t            w_next;

    logic                  r_ptr;      // last granted port (1 = r1)
    logic                  r_id;       // port owning the current transaction
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;    // shared response register

    logic [1:0]            w_pick;
    logic                  w_accept;
    logic                  w_win_id;

    rr_picker u_rr_picker (
        .req  ({r1_req, r0_req}),
        .last (r_ptr),
        .gnt  (w_pick)
    );

    assign w_win_id = w_pick[1];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and outputs. Grants are combinational so a requester
    // sees acceptance in the same IDLE cycle its request is sampled.
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        r0_gnt    = 1'b0;
        r1_gnt    = 1'b0;
        r0_rvalid = 1'b0;
        r1_rvalid = 1'b0;
        mem_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_pick) begin
                    w_accept = 1'b1;
                    r0_gnt   = w_pick[0];
                    r1_gnt   = w_pick[1];
                    w_next   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_we = r_we;
                w_next = r_we ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                r0_rvalid = ~r_id;
                r1_rvalid = r_id;
                w_next    = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction capture and read response. The captured address and
    // data only change on accept, so driving the memory bus straight from
    // them gives the required hold behaviour outside ISSUE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= 1'b1;          // r0 wins the first contention
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_ptr   <= w_win_id;
                r_id    <= w_win_id;
                r_we    <= w_win_id ? r1_we    : r0_we;
                r_addr  <= w_win_id ? r1_addr  : r0_addr;
                r_wdata <= w_win_id ? r1_wdata : r0_wdata;
            end
            if (r_state == ST_WAIT) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign r0_rdata  = r_rdata;
    assign r1_rdata  = r_rdata;
    assign busy      = (r_state != ST_IDLE);

endmodule : mem_arbiter
`default_nettype wire
